// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   PORT_CPU / PORT_LOAD : requester indices (CPU data port, debug/loader port)
//   NUM_PORTS            : number of requesters
//   ret_entry_t          : one slot of the read-return pipeline {valid, port}
//   req_t                : one requester's access bundle {req, we, addr, wdata}
// BUS_ADDR_W / BUS_DATA_W size the req_t fields. They match the arbiter's
// default ADDR_W / DATA_W. The arbiter casts between req_t and its own port
// widths, so the two must stay in step if either one changes.
package dmem_arb_pkg;

  localparam int   NUM_PORTS  = 2;
  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  localparam int   BUS_ADDR_W = 32;
  localparam int   BUS_DATA_W = 32;

  typedef struct packed {
    logic valid;
    logic port;
  } ret_entry_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector.
//   clk, reset : clock and asynchronous active-high reset
//   req        : request vector, bit index = port id
//   gnt        : one-hot (or zero) grant, combinational within the cycle
//   gnt_port   : index of the granted port; meaningful only when |gnt
// When both ports request, the grant goes to the port that did not win the
// last grant. Grants are forced low while reset is high, so requests that
// arrive during reset are ignored.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 gnt_port
);

  logic last_gnt;

  always_comb begin
    // NOTE: give every output of an always_comb a default first. Otherwise a
    // path that does not assign it infers a latch.
    gnt = '0;
    if (!reset) begin
      if (req[PORT_CPU] && req[PORT_LOAD]) begin
        if (last_gnt == PORT_LOAD) gnt[PORT_CPU]  = 1'b1;
        else                       gnt[PORT_LOAD] = 1'b1;
      end else if (req[PORT_CPU]) begin
        gnt[PORT_CPU] = 1'b1;
      end else if (req[PORT_LOAD]) begin
        gnt[PORT_LOAD] = 1'b1;
      end
    end
  end

  assign gnt_port = gnt[PORT_LOAD];

  // Reset to PORT_LOAD so that the CPU port wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments. Every register then
    // samples its pre-edge value, whatever the order of the statements.
    if (reset)     last_gnt <= PORT_LOAD;
    else if (|gnt) last_gnt <= gnt_port;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the CPU data port (p0) and
// the debug/loader port (p1).
//   clk, reset            : clock and asynchronous active-high reset
//   pN_req/we/addr/wdata  : requester access; hold stable until pN_gnt is seen
//   pN_gnt                : access accepted this cycle
//   pN_rvalid / pN_rdata  : read return, READ_LAT cycles after the grant;
//                           rdata holds its last value between returns
//   mem_en/we/addr/wdata  : strobe and access forwarded to the memory
//   mem_rdata             : memory read data, READ_LAT cycles after mem_en
// Reads are tagged with the granting port as they travel down a
// READ_LAT-deep shift register. Back-to-back reads from either port
// therefore need no bubble. READ_LAT = 0 routes the return in the grant cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  req_t                 p0_bus, p1_bus;
  logic [NUM_PORTS-1:0] gnt;
  logic                 gnt_port;
  logic                 any_gnt;
  logic                 win_we;
  logic [BUS_ADDR_W-1:0] win_addr;
  logic [BUS_DATA_W-1:0] win_wdata;
  ret_entry_t           issue, ret;
  logic [DATA_W-1:0]    p0_hold, p1_hold;

  assign p0_bus = '{req: p0_req, we: p0_we,
                    addr: BUS_ADDR_W'(p0_addr), wdata: BUS_DATA_W'(p0_wdata)};
  assign p1_bus = '{req: p1_req, we: p1_we,
                    addr: BUS_ADDR_W'(p1_addr), wdata: BUS_DATA_W'(p1_wdata)};

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({p1_bus.req, p0_bus.req}),
    .gnt      (gnt),
    .gnt_port (gnt_port)
  );

  assign p0_gnt  = gnt[PORT_CPU];
  assign p1_gnt  = gnt[PORT_LOAD];
  assign any_gnt = |gnt;

  assign win_we    = (gnt_port == PORT_LOAD) ? p1_bus.we    : p0_bus.we;
  assign win_addr  = (gnt_port == PORT_LOAD) ? p1_bus.addr  : p0_bus.addr;
  assign win_wdata = (gnt_port == PORT_LOAD) ? p1_bus.wdata : p0_bus.wdata;

  // With no grant, the memory sees an idle, all-zero access.
  assign mem_en    = any_gnt;
  assign mem_we    = any_gnt & win_we;
  assign mem_addr  = any_gnt ? ADDR_W'(win_addr)  : '0;
  assign mem_wdata = any_gnt ? DATA_W'(win_wdata) : '0;

  // Writes complete in the grant cycle. Only reads enter the return path.
  assign issue = '{valid: any_gnt & ~win_we, port: gnt_port};

  generate
    if (READ_LAT == 0) begin : g_comb_ret
      assign ret = issue;
    end else begin : g_pipe_ret
      ret_entry_t pipe [READ_LAT];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          // NOTE: only the valid bits need a reset, because they are the
          // only state that can cause a stray return after reset. The port
          // tags are cleared as well because the array is small.
          for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= issue;
          for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign ret = pipe[READ_LAT-1];
    end
  endgenerate

  assign p0_rvalid = ret.valid & (ret.port == PORT_CPU);
  assign p1_rvalid = ret.valid & (ret.port == PORT_LOAD);

  // On a return the memory data passes straight through. The hold register
  // keeps that port's rdata steady until its next return.
  assign p0_rdata = p0_rvalid ? mem_rdata : p0_hold;
  assign p1_rdata = p1_rvalid ? mem_rdata : p1_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_hold <= '0;
      p1_hold <= '0;
    end else begin
      if (p0_rvalid) p0_hold <= mem_rdata;
      if (p1_rvalid) p1_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Two instances share one set of
// requester inputs: dut_a uses READ_LAT = 1 and dut_b uses READ_LAT = 0.
// Each instance has its own behavioural memory. A reference model tracks
// the round-robin preference, the memory contents and a scoreboard of
// expected returns keyed by due cycle. It checks both instances every cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(0)) dut_b (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Behavioural memories: dut_a has a registered read, dut_b a combinational one.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
      else          a_mem_rdata <= mem_a[a_mem_addr[9:2]];
    end
  end

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
  end
  assign b_mem_rdata = mem_b[b_mem_addr[9:2]];

  typedef struct packed {
    logic g0, g1, rv0, rv1, en, we;
    logic [31:0] rd0, rd1, addr, wdata;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_mem_en, a_mem_we,
                  a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata};
  assign obs_b = {b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid, b_mem_en, b_mem_we,
                  b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  int          prefer;             // port that wins the next tie
  int          cyc;
  int          last_win;
  int          lat_of [2] = '{1, 0};
  bit          sb_v [2][2][8];     // [dut][port][due cycle mod 8]
  logic [31:0] sb_d [2][2][8];
  logic [31:0] last_rd [2][2];

  task automatic model_reset();
    prefer = 0;
    last_win = -1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        last_rd[d][p] = '0;
        for (int s = 0; s < 8; s++) sb_v[d][p][s] = 1'b0;
      end
  endtask

  task automatic model_and_check();
    int          win;
    int          slot;
    obs_t        o;
    logic        ewe, rv;
    logic [31:0] eaddr, ewd, rd;
    win = -1;
    if (p0_req && p1_req) win = prefer;
    else if (p0_req)      win = 0;
    else if (p1_req)      win = 1;
    ewe   = (win == 0) ? p0_we    : (win == 1) ? p1_we    : 1'b0;
    eaddr = (win == 0) ? p0_addr  : (win == 1) ? p1_addr  : 32'h0;
    ewd   = (win == 0) ? p0_wdata : (win == 1) ? p1_wdata : 32'h0;
    for (int d = 0; d < 2; d++) begin
      o = (d == 0) ? obs_a : obs_b;
      check($sformatf("d%0d_p0_gnt@%0d", d, cyc), 32'(o.g0), 32'(win == 0));
      check($sformatf("d%0d_p1_gnt@%0d", d, cyc), 32'(o.g1), 32'(win == 1));
      check($sformatf("d%0d_mem_en@%0d", d, cyc), 32'(o.en), 32'(win >= 0));
      check($sformatf("d%0d_mem_we@%0d", d, cyc), 32'(o.we), 32'(ewe));
      check($sformatf("d%0d_mem_addr@%0d", d, cyc), o.addr, eaddr);
      check($sformatf("d%0d_mem_wdata@%0d", d, cyc), o.wdata, ewd);
      if (win >= 0 && !ewe) begin
        slot = (cyc + lat_of[d]) % 8;
        sb_v[d][win][slot] = 1'b1;
        sb_d[d][win][slot] = ref_mem[eaddr[9:2]];
      end
      slot = cyc % 8;
      for (int p = 0; p < 2; p++) begin
        rv = (p == 0) ? o.rv0 : o.rv1;
        rd = (p == 0) ? o.rd0 : o.rd1;
        check($sformatf("d%0d_p%0d_rvalid@%0d", d, p, cyc), 32'(rv), 32'(sb_v[d][p][slot]));
        if (sb_v[d][p][slot]) begin
          check($sformatf("d%0d_p%0d_rdata@%0d", d, p, cyc), rd, sb_d[d][p][slot]);
          last_rd[d][p] = sb_d[d][p][slot];
          sb_v[d][p][slot] = 1'b0;
        end else begin
          check($sformatf("d%0d_p%0d_rdata_hold@%0d", d, p, cyc), rd, last_rd[d][p]);
        end
      end
    end
    if (win >= 0) begin
      if (ewe) ref_mem[eaddr[9:2]] = ewd;
      prefer = 1 - win;
    end
    last_win = win;
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_and_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    settle();
    advance();
  endtask

  task automatic check_all_zero(input string tag);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = (d == 0) ? obs_a : obs_b;
      check($sformatf("%s_d%0d_p0_gnt", tag, d), 32'(o.g0), 32'h0);
      check($sformatf("%s_d%0d_p1_gnt", tag, d), 32'(o.g1), 32'h0);
      check($sformatf("%s_d%0d_mem_en", tag, d), 32'(o.en), 32'h0);
      check($sformatf("%s_d%0d_mem_we", tag, d), 32'(o.we), 32'h0);
      check($sformatf("%s_d%0d_p0_rvalid", tag, d), 32'(o.rv0), 32'h0);
      check($sformatf("%s_d%0d_p1_rvalid", tag, d), 32'(o.rv1), 32'h0);
      check($sformatf("%s_d%0d_p0_rdata", tag, d), o.rd0, 32'h0);
      check($sformatf("%s_d%0d_p1_rdata", tag, d), o.rd1, 32'h0);
      check($sformatf("%s_d%0d_mem_addr", tag, d), o.addr, 32'h0);
      check($sformatf("%s_d%0d_mem_wdata", tag, d), o.wdata, 32'h0);
    end
  endtask

  // ---------------- directed vectors (expectations for dut_a, READ_LAT=1) ----------------
  typedef struct packed {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic g0, g1, mwe;
    logic rv0; logic [31:0] rd0;
    logic rv1; logic [31:0] rd1;
  } vec_t;

  vec_t tbl [17];

  // ---------------- random stimulus state ----------------
  bit          pend [2];
  logic        we_r [2];
  logic [31:0] a_r [2], d_r [2];

  initial begin
    cyc = 0;
    model_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    #1 check_all_zero("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: nothing granted, nothing returned.
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    //             r0    w0    a0      d0            r1    w1    a1      d1            g0    g1    mwe   rv0   rd0           rv1   rd1
    tbl[0]  = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h80, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h20, 32'h11112222, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h80, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5};
    tbl[10] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 1'b0, 32'h80, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h11112222, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678};
    tbl[12] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5};
    tbl[14] = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h11112222, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[16] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      settle();
      check($sformatf("vec%0d_p0_gnt", i), 32'(a_p0_gnt), 32'(tbl[i].g0));
      check($sformatf("vec%0d_p1_gnt", i), 32'(a_p1_gnt), 32'(tbl[i].g1));
      check($sformatf("vec%0d_mem_we", i), 32'(a_mem_we), 32'(tbl[i].mwe));
      check($sformatf("vec%0d_p0_rvalid", i), 32'(a_p0_rvalid), 32'(tbl[i].rv0));
      check($sformatf("vec%0d_p1_rvalid", i), 32'(a_p1_rvalid), 32'(tbl[i].rv1));
      if (tbl[i].rv0) check($sformatf("vec%0d_p0_rdata", i), a_p0_rdata, tbl[i].rd0);
      if (tbl[i].rv1) check($sformatf("vec%0d_p1_rdata", i), a_p1_rdata, tbl[i].rd1);
      advance();
    end

    // Zero-latency instance: grant, rvalid and rdata all in the same cycle.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    settle();
    check("lat0_p1_gnt", 32'(b_p1_gnt), 32'h1);
    check("lat0_p1_rvalid", 32'(b_p1_rvalid), 32'h1);
    check("lat0_p1_rdata", b_p1_rdata, 32'hA5A5A5A5);
    advance();

    // A read in flight is killed by a one-cycle reset. The outputs drop
    // without a clock edge, and the next tie goes to p0.
    cycle(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    #1 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    settle();
    check("post_reset_tie_p0_gnt", 32'(a_p0_gnt), 32'h1);
    check("post_reset_tie_p1_gnt", 32'(a_p1_gnt), 32'h0);
    advance();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Give every word that random traffic can address a known value.
    for (int w = 0; w < 16; w++)
      cycle(1'b1, 1'b1, 32'(w) << 2, 32'hC0DE0000 + 32'(w), 1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic that follows the handshake, with occasional abandonment.
    last_win = -1;
    for (int p = 0; p < 2; p++) pend[p] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && last_win == p)                     pend[p] = 1'b0;
        else if (pend[p] && $urandom_range(0, 19) == 0)   pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(0, 9) < 6) begin
          pend[p] = 1'b1;
          we_r[p] = ($urandom_range(0, 2) == 0);
          a_r[p]  = 32'($urandom_range(0, 15)) << 2;
          d_r[p]  = $urandom;
        end
      end
      cycle(pend[0], we_r[0], a_r[0], d_r[0], pend[1], we_r[1], a_r[1], d_r[1]);
    end

    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory between two requesters: port 0 is the CPU data port and port 1 is the debug/loader port (program load, memory dump).
- Sits between the mips32Single data interface and dataMemory.
- Round-robin arbitration with one grant per cycle.
- Read data is routed back to the granted port after a fixed memory read latency, so reads from both ports can be in flight at once.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, byte-address width on the requester ports.
- READ_LAT, 1, memory read latency in cycles; legal range 0..4. A value of 0 means the memory has a combinational read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  CPU access request
- p0_we  in  1  CPU write enable (1 = write)
- p0_addr  in  ADDR_W  CPU byte address
- p0_wdata  in  DATA_W  CPU write data
- p0_gnt  out  1  CPU access accepted this cycle
- p0_rvalid  out  1  CPU read data valid
- p0_rdata  out  DATA_W  CPU read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: the same set of signals for the loader port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  byte address forwarded to memory
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Single clock domain on clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - last_gnt = 1, so port 0 wins the first tie.
  - The read-return pipeline valid bits are all 0.
  - All gnt, rvalid, mem_en and mem_we outputs are 0.
  - Data outputs are 0.
- Requester handshake:
  - A requester asserts req and holds we/addr/wdata stable until it sees gnt high on a rising edge.
  - The access is accepted on the cycle where req && gnt.
  - The requester may drop req, or present a new access, on the following cycle.
- Arbitration (combinational within the cycle):
  - Only p0_req set: grant p0.
  - Only p1_req set: grant p1.
  - Both set: grant the port that is not last_gnt.
  - Neither set: no grant, mem_en = 0, last_gnt unchanged.
  - At most one gnt is high in any cycle.
- last_gnt update: registered on every cycle with a grant, taking the granted port index. Under continuous contention this gives a strict alternation of grants.
- Memory drive:
  - mem_en = |gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the winning port.
  - With no grant, mem_we = 0 and the address and data outputs hold 0.
- Writes complete in the grant cycle. No rvalid is produced for a write.
- Reads:
  - A granted read pushes {valid = 1, port id} into a READ_LAT-deep shift register.
  - When the entry reaches the end of the shift register, the selected port's rvalid is pulsed for one cycle and mem_rdata is passed through to its rdata.
  - The non-selected port's rdata holds its last value; rvalid is low.
  - READ_LAT = 0: rvalid is combinational in the grant cycle and equals gnt && !we.
- Pipelining:
  - Back-to-back reads from either port issue every cycle. There is no bubble, because returns are tagged.
  - The order of returns per port matches the order in which that port's accesses were issued.
- Read-after-write to the same address from different ports, granted in consecutive cycles, returns the new data; the arbiter does no reordering.
- If req is dropped before gnt, the request is abandoned with no side effects.
- Reset mid-operation: in-flight read returns are discarded, so no rvalid follows reset deassertion for reads issued before it. last_gnt returns to 1.
- Requests arriving during reset are ignored. The first grant can occur in the first cycle after reset deasserts.

Decomposition:
- Package dmem_arb_pkg holds:
  - Constants PORT_CPU = 0 and PORT_LOAD = 1, plus NUM_PORTS = 2.
  - A typedef for the return-pipeline entry: struct {logic valid; logic port;}.
  - A typedef for the request bundle: struct {req, we, addr, wdata}.
- Sub-module rr_arbiter2: pure two-way round-robin selector with registered last_gnt. It is instantiated once. The read-return pipeline and the muxing stay in dmem_arbiter.

Test Plan:
- Reset, then no requests for 5 cycles -> all gnt = 0, mem_en = 0 and rvalid = 0 throughout. Assert reset mid-test -> outputs return to 0 immediately, without waiting for clk.
- p0 writes 0xDEADBEEF to 0x40, then p0 reads 0x40 (READ_LAT = 1) -> gnt is high each cycle, mem_we = 1 then 0, and p0_rvalid rises one cycle after the read grant with p0_rdata = 0xDEADBEEF; p1_rvalid stays 0.
- p0 and p1 both hold read requests for 6 cycles -> grants alternate p0, p1, p0, p1, p0, p1, and each rvalid pulse carries the data for that port's own address.
- p1 writes 0x12345678 to 0x80 in cycle N and p0 reads 0x80 in cycle N+1 -> p0_rdata = 0x12345678.
- p0 issues a read, then reset is pulsed for 1 cycle before the return -> no p0_rvalid after reset deasserts; the next simultaneous request grants p0 first.
- READ_LAT = 0 build: p1 reads 0x10 containing 0xA5A5A5A5 -> p1_gnt, p1_rvalid and p1_rdata = 0xA5A5A5A5 all in the same cycle.
